// File: rtl/byte_memory_pkg.sv
// Shared definitions for the byteMemory front end: bus widths, arbiter
// state encoding and the width helper for the start-timeout counter.
package byte_memory_pkg;

    localparam int MEM_ADDR_SIZE_DEF   = 32;
    localparam int MEM_WORD_SIZE_DEF   = 32;
    localparam int MEM_STROBE_BITS_DEF = 4;
    localparam int BURST_BITS_DEF      = 2;
    localparam int START_TIMEOUT_DEF   = 8;

    // Counter must hold values 0 .. START_TIMEOUT-1; never narrower than 1 bit.
    function automatic int timeout_cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    localparam int TIMEOUT_CNT_W = timeout_cnt_width(START_TIMEOUT_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, the port that did not win
// last time has priority when both request.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // Contention goes to the port other than last_grant; a lone request wins outright.
    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/byte_memory_arbiter.sv
// Shares one byteMemory between two requesters. A granted request is latched,
// driven onto the memory bus until busy falls, and answered with a single
// response pulse on the port that issued it.
module byte_memory_arbiter
    import byte_memory_pkg::*;
#(
    parameter int MEM_ADDR_SIZE   = MEM_ADDR_SIZE_DEF,
    parameter int MEM_WORD_SIZE   = MEM_WORD_SIZE_DEF,
    parameter int MEM_STROBE_BITS = MEM_STROBE_BITS_DEF,
    parameter int BURST_BITS      = BURST_BITS_DEF,
    parameter int START_TIMEOUT   = START_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       req0Valid,
    output logic                       req0Ready,
    input  logic [MEM_ADDR_SIZE-1:0]   req0Addr,
    input  logic                       req0Wr,
    input  logic [MEM_STROBE_BITS-1:0] req0Strb,
    input  logic [BURST_BITS-1:0]      req0Burst,
    input  logic [MEM_WORD_SIZE-1:0]   req0DataIn,
    output logic                       rsp0Valid,
    output logic [MEM_WORD_SIZE-1:0]   rsp0Data,
    output logic                       rsp0Err,

    input  logic                       req1Valid,
    output logic                       req1Ready,
    input  logic [MEM_ADDR_SIZE-1:0]   req1Addr,
    input  logic                       req1Wr,
    input  logic [MEM_STROBE_BITS-1:0] req1Strb,
    input  logic [BURST_BITS-1:0]      req1Burst,
    input  logic [MEM_WORD_SIZE-1:0]   req1DataIn,
    output logic                       rsp1Valid,
    output logic [MEM_WORD_SIZE-1:0]   rsp1Data,
    output logic                       rsp1Err,

    output logic [MEM_ADDR_SIZE-1:0]   memAddr,
    output logic [MEM_WORD_SIZE-1:0]   memDataIn,
    output logic [MEM_STROBE_BITS-1:0] memStrb,
    output logic                       memWr,
    output logic [BURST_BITS-1:0]      memBurstLen,
    input  logic                       memBusyOut,
    input  logic [MEM_WORD_SIZE-1:0]   memDataOut
);

    localparam int CNT_W = timeout_cnt_width(START_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    // Per-port views of the request buses so the winner can be selected by index.
    logic [1:0]                 req_valid;
    logic [MEM_ADDR_SIZE-1:0]   req_addr  [2];
    logic                       req_wr    [2];
    logic [MEM_STROBE_BITS-1:0] req_strb  [2];
    logic [BURST_BITS-1:0]      req_burst [2];
    logic [MEM_WORD_SIZE-1:0]   req_data  [2];

    assign req_valid    = {req1Valid, req0Valid};
    assign req_addr[0]  = req0Addr;
    assign req_addr[1]  = req1Addr;
    assign req_wr[0]    = req0Wr;
    assign req_wr[1]    = req1Wr;
    assign req_strb[0]  = req0Strb;
    assign req_strb[1]  = req1Strb;
    assign req_burst[0] = req0Burst;
    assign req_burst[1] = req1Burst;
    assign req_data[0]  = req0DataIn;
    assign req_data[1]  = req1DataIn;

    arb_state_e                 state_q, state_d;
    logic                       last_grant_q, last_grant_d;
    logic                       gid_q, gid_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [MEM_ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [MEM_WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MEM_STROBE_BITS-1:0] mem_strb_q, mem_strb_d;
    logic                       mem_wr_q, mem_wr_d;
    logic [BURST_BITS-1:0]      mem_burst_q, mem_burst_d;
    logic [MEM_WORD_SIZE-1:0]   rsp_data_q [2];
    logic [MEM_WORD_SIZE-1:0]   rsp_data_d [2];
    logic                       rsp_err_q  [2];
    logic                       rsp_err_d  [2];

    logic [1:0] grant;
    logic       sel;

    rr_arbiter2 u_rr_arbiter2 (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign sel = grant[1];

    // Ready is only offered to the winner while idle, and never while reset is held.
    assign req0Ready = reset && (state_q == ST_IDLE) && grant[0];
    assign req1Ready = reset && (state_q == ST_IDLE) && grant[1];

    assign rsp0Valid = (state_q == ST_RESP) && (gid_q == 1'b0);
    assign rsp1Valid = (state_q == ST_RESP) && (gid_q == 1'b1);
    assign rsp0Data  = rsp_data_q[0];
    assign rsp1Data  = rsp_data_q[1];
    assign rsp0Err   = rsp_err_q[0];
    assign rsp1Err   = rsp_err_q[1];

    // The memory bus registers double as the request latch; only memStrb is
    // cleared when the transaction ends, the rest keep their last values.
    assign memAddr     = mem_addr_q;
    assign memDataIn   = mem_wdata_q;
    assign memStrb     = mem_strb_q;
    assign memWr       = mem_wr_q;
    assign memBurstLen = mem_burst_q;

    // Next-state logic: accept, issue with start timeout, wait for busy to fall, respond.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_strb_d   = mem_strb_q;
        mem_wr_d     = mem_wr_q;
        mem_burst_d  = mem_burst_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    gid_d       = sel;
                    cnt_d       = '0;
                    mem_addr_d  = req_addr[sel];
                    mem_wdata_d = req_data[sel];
                    mem_strb_d  = req_strb[sel];
                    mem_wr_d    = req_wr[sel];
                    mem_burst_d = req_burst[sel];
                    if (req_strb[sel] != '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // Empty strobe: nothing to do in memory, answer at once.
                        state_d         = ST_RESP;
                        rsp_data_d[sel] = '0;
                        rsp_err_d[sel]  = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                // A busy already high (stale) is treated as the access having started.
                if (memBusyOut) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d           = ST_RESP;
                    mem_strb_d        = '0;
                    rsp_data_d[gid_q] = '0;
                    rsp_err_d[gid_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!memBusyOut) begin
                    state_d           = ST_RESP;
                    mem_strb_d        = '0;
                    rsp_data_d[gid_q] = mem_wr_q ? '0 : memDataOut;
                    rsp_err_d[gid_q]  = 1'b0;
                end
            end
            ST_RESP: begin
                last_grant_d = gid_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_strb_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_burst_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                rsp_data_q[i] <= '0;
                rsp_err_q[i]  <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_strb_q   <= mem_strb_d;
            mem_wr_q     <= mem_wr_d;
            mem_burst_q  <= mem_burst_d;
            for (int i = 0; i < 2; i++) begin
                rsp_data_q[i] <= rsp_data_d[i];
                rsp_err_q[i]  <= rsp_err_d[i];
            end
        end
    end

endmodule

// File: tb/tb_byte_memory_arbiter.sv
// Directed bench for byte_memory_arbiter with a behavioural byteMemory and a
// response scoreboard.
module tb_byte_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0Valid, req0Ready, req0Wr, rsp0Valid, rsp0Err;
    logic [31:0] req0Addr, req0DataIn, rsp0Data;
    logic [3:0]  req0Strb;
    logic [1:0]  req0Burst;
    logic        req1Valid, req1Ready, req1Wr, rsp1Valid, rsp1Err;
    logic [31:0] req1Addr, req1DataIn, rsp1Data;
    logic [3:0]  req1Strb;
    logic [1:0]  req1Burst;
    logic [31:0] memAddr, memDataIn, memDataOut;
    logic [3:0]  memStrb;
    logic        memWr, memBusyOut;
    logic [1:0]  memBurstLen;

    always #5 clk = ~clk;

    byte_memory_arbiter dut (
        .clk(clk), .reset(reset),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr), .req0Wr(req0Wr),
        .req0Strb(req0Strb), .req0Burst(req0Burst), .req0DataIn(req0DataIn),
        .rsp0Valid(rsp0Valid), .rsp0Data(rsp0Data), .rsp0Err(rsp0Err),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr), .req1Wr(req1Wr),
        .req1Strb(req1Strb), .req1Burst(req1Burst), .req1DataIn(req1DataIn),
        .rsp1Valid(rsp1Valid), .rsp1Data(rsp1Data), .rsp1Err(rsp1Err),
        .memAddr(memAddr), .memDataIn(memDataIn), .memStrb(memStrb), .memWr(memWr),
        .memBurstLen(memBurstLen), .memBusyOut(memBusyOut), .memDataOut(memDataOut)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural byteMemory ----------------
    logic [31:0] mem_arr [16];
    logic        mem_armed;
    bit          mem_dead = 1'b0;
    int          mem_lat = 3;
    int          mem_cnt;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    initial for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            memBusyOut <= 1'b0;
            memDataOut <= 32'h0;
            mem_armed  <= 1'b1;
            mem_cnt    <= 0;
        end else begin
            if (memStrb == 4'h0) mem_armed <= 1'b1;
            if (memBusyOut) begin
                if (mem_cnt == 0) memBusyOut <= 1'b0;
                else mem_cnt <= mem_cnt - 1;
            end else if (memStrb != 4'h0 && mem_armed && !mem_dead) begin
                mem_armed  <= 1'b0;
                memBusyOut <= 1'b1;
                mem_cnt    <= mem_lat - 1;
                if (memWr) begin
                    mem_arr[memAddr[5:2]] <= merge(mem_arr[memAddr[5:2]], memDataIn, memStrb);
                    memDataOut <= 32'h0;
                end else begin
                    memDataOut <= mem_arr[memAddr[5:2]];
                end
            end
        end
    end

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        bit          chk_data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_addr = '0, exp_din = '0;
    logic [3:0]  exp_strb = '0;
    logic        exp_wr = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (memStrb != 4'h0) begin
                chk("mem_strb_hold", memStrb, exp_strb);
                chk("mem_addr_hold", memAddr, exp_addr);
                chk("mem_din_hold", memDataIn, exp_din);
                chk("mem_wr_hold", memWr, exp_wr);
            end
            if (rsp0Valid || rsp1Valid) begin
                chk("rsp_single_port", rsp0Valid && rsp1Valid, 1'b0);
                chk("rsp_memstrb_zero", memStrb, 4'h0);
                if (sb.size() == 0) begin
                    mismatched++;
                    $error("FAIL rsp_unexpected: observed response with port %0d expected none",
                           rsp1Valid ? 1 : 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_port", rsp1Valid ? 1 : 0, mon_e.port);
                    chk("rsp_err", rsp1Valid ? rsp1Err : rsp0Err, mon_e.err);
                    if (mon_e.chk_data) chk("rsp_data", rsp1Valid ? rsp1Data : rsp0Data, mon_e.data);
                    if (mon_e.lat >= 0) chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
                    $display("rsp port%0d data=%08h err=%0d cyc=%0d",
                             rsp1Valid ? 1 : 0, rsp1Valid ? rsp1Data : rsp0Data,
                             rsp1Valid ? rsp1Err : rsp0Err, cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_port(input int port, input logic v, input logic [31:0] addr,
                              input logic wr, input logic [3:0] strb, input logic [31:0] data);
        if (port == 0) begin
            req0Valid = v; req0Addr = addr; req0Wr = wr; req0Strb = strb; req0DataIn = data; req0Burst = 2'd0;
        end else begin
            req1Valid = v; req1Addr = addr; req1Wr = wr; req1Strb = strb; req1DataIn = data; req1Burst = 2'd0;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            mismatched++;
            $error("FAIL rsp_timeout: observed %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_req(input int port, input logic [31:0] addr, input logic wr,
                          input logic [3:0] strb, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_err,
                          input bit chk_data, input int lat, input bit push);
        int  w;
        bit  got;
        @(negedge clk);
        drive_port(port, 1'b1, addr, wr, strb, data);
        w = 0;
        got = 0;
        while (!got && w < 100) begin
            #1;
            if ((port == 0) ? req0Ready : req1Ready) got = 1;
            else begin
                @(negedge clk);
                w++;
            end
        end
        if (!got) begin
            mismatched++;
            $error("FAIL accept_timeout: observed no ready on port %0d expected ready", port);
            drive_port(port, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            return;
        end
        chk("ready_other_port", (port == 0) ? req1Ready : req0Ready, 1'b0);
        @(posedge clk);
        #1;
        // Scramble the request inputs to show the arbiter works from its latch.
        drive_port(port, 1'b0, ~addr, ~wr, ~strb, ~data);
        exp_addr = addr; exp_din = data; exp_strb = strb; exp_wr = wr;
        $display("req port%0d addr=%08h wr=%0d strb=%h data=%08h cyc=%0d", port, addr, wr, strb, data, cyc);
        if (push) begin
            sb.push_back('{port, exp_data, exp_err, chk_data, lat, cyc});
            wait_drain();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int g;
        int order [4];
        order = '{0, 1, 0, 1};

        drive_port(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
        drive_port(1, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_memstrb", memStrb, 4'h0);
        chk("reset_memaddr", memAddr, 32'h0);
        chk("reset_memwr", memWr, 1'b0);
        chk("reset_memdin", memDataIn, 32'h0);
        chk("reset_memburst", memBurstLen, 2'd0);
        chk("reset_ready", {req1Ready, req0Ready}, 2'b00);
        chk("reset_rspvalid", {rsp1Valid, rsp0Valid}, 2'b00);
        chk("reset_rspdata", {rsp1Data, rsp0Data}, 64'h0);
        chk("reset_rsperr", {rsp1Err, rsp0Err}, 2'b00);
        drive_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        reset = 1'b1;

        // Port 0 write, then port 1 reads it back.
        do_req(0, 32'h0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1, -1, 1);
        do_req(1, 32'h0, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1, -1, 1);

        // Reset asserted while the memory is busy: request dropped, no response.
        mem_lat = 10;
        do_req(1, 32'h8, 1'b1, 4'hF, 32'h55555555, 32'h0, 1'b0, 1, -1, 0);
        w = 0;
        while (!memBusyOut && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("midwait_busy", memBusyOut, 1'b1);
        @(negedge clk);
        chk("midwait_strb_before", memStrb, 4'hF);
        reset = 1'b0;
        #1;
        chk("midwait_strb_reset", memStrb, 4'h0);
        chk("midwait_rsp_reset", {rsp1Valid, rsp0Valid}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        mem_lat = 3;

        // Both ports valid continuously: grants alternate starting at port 0.
        drive_port(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
        drive_port(1, 1'b1, 32'h4, 1'b1, 4'hF, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            w = 0;
            #1;
            while (!(req0Ready || req1Ready) && w < 100) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (k == 0) chk("contend_first_wait", w, 0);
            chk("contend_both_ready", req0Ready && req1Ready, 1'b0);
            g = req1Ready ? 1 : 0;
            chk("contend_grant_order", g, order[k]);
            chk("contend_idle_gap_strb", memStrb, 4'h0);
            @(posedge clk);
            #1;
            if (g == 0) begin
                exp_addr = 32'h0; exp_din = 32'h0; exp_strb = 4'hF; exp_wr = 1'b0;
                sb.push_back('{0, 32'hDEADBEEF, 1'b0, 1, -1, cyc});
            end else begin
                exp_addr = 32'h4; exp_din = 32'h12345678; exp_strb = 4'hF; exp_wr = 1'b1;
                sb.push_back('{1, 32'h0, 1'b0, 1, -1, cyc});
            end
            $display("contend accept %0d port%0d cyc=%0d", k, g, cyc);
        end
        drive_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        wait_drain();

        // Memory never starts: error response after 8 ISSUE cycles, then normal service.
        mem_dead = 1'b1;
        do_req(0, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 0, 8, 1);
        mem_dead = 1'b0;
        do_req(1, 32'h4, 1'b0, 4'hF, 32'h0, 32'h12345678, 1'b0, 1, -1, 1);

        // Zero strobe: answered the cycle after accept, memory untouched.
        do_req(0, 32'h0, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 0, 1);
        do_req(1, 32'h0, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1, -1, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
